// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: MIPS IF stage.
// PC generation, SRAM req/ack, 2-entry FIFO, delayed-branch redirect.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [32:0] br_bus,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [32:0] if_to_id_bus,
  output logic [31:0] if_inst
);

  localparam logic STOP = 1'b1;

  logic        br_e;
  logic [31:0] br_addr;

  logic [31:0] pc;
  logic [31:0] pc_inflight;
  logic [31:0] pend_addr;
  logic        pend_valid;
  logic        inflight;
  logic        discard;
  logic        boot;

  logic [31:0] q_pc   [2];
  logic [31:0] q_inst [2];
  logic [1:0]  q_cnt;

  logic        head_v;
  logic        pop;
  logic        push;
  logic        accept;
  logic        redirect;
  logic        held;
  logic        flush;
  logic [2:0]  occ;
  logic [1:0]  slot;
  logic        unused_stall;

  assign {br_e, br_addr} = br_bus;
  assign unused_stall    = ^stall[5:3];

  assign head_v   = q_cnt != 2'd0;
  assign pop      = head_v && stall[1] != STOP;
  assign redirect = br_e && stall[2] != STOP;

  // delay slot candidates: head, else a live in-flight word
  assign held  = head_v || (inflight && !discard);
  assign flush = redirect && head_v;

  assign occ = {1'b0, q_cnt}
             + {2'b0, inflight}
             - {2'b0, pop};

  assign inst_req = !rst && !boot
                 && stall[0] != STOP
                 && (!inflight || inst_data_ok)
                 && occ < 3'd2;
  assign inst_addr = pc;
  assign accept    = inst_req && inst_addr_ok;

  // words behind a valid head are wrong-path once redirected
  assign push = inst_data_ok && inflight
             && !discard && !flush;
  assign slot = q_cnt - {1'b0, pop};

  assign if_to_id_bus = head_v ? {1'b1, q_pc[0]} : 33'd0;
  assign if_inst      = head_v ? q_inst[0] : 32'd0;

  // FIFO occupancy; a redirect keeps only the head
  always_ff @(posedge clk) begin
    if (rst) begin
      q_cnt <= 2'd0;
    end else if (flush) begin
      q_cnt <= pop ? 2'd0 : 2'd1;
    end else begin
      q_cnt <= slot + {1'b0, push};
    end
  end

  // FIFO payload: shift on pop, write at first free slot
  always_ff @(posedge clk) begin
    if (pop) begin
      q_pc[0]   <= q_pc[1];
      q_inst[0] <= q_inst[1];
    end
    if (push) begin
      q_pc[slot[0]]   <= pc_inflight;
      q_inst[slot[0]] <= inst_rdata;
    end
  end

  // request tracking, pc update and deferred redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      pc_inflight <= RESET_PC;
      inflight    <= 1'b0;
      discard     <= 1'b0;
      pend_valid  <= 1'b0;
      pend_addr   <= 32'd0;
      boot        <= 1'b1;
    end else begin
      boot <= 1'b0;
      if (accept) begin
        inflight    <= 1'b1;
        pc_inflight <= pc;
        discard     <= redirect && held;
      end else if (inst_data_ok && inflight) begin
        inflight <= 1'b0;
        discard  <= 1'b0;
      end else if (flush && inflight) begin
        discard <= 1'b1;
      end
      if (redirect) begin
        if (held || accept) begin
          pc <= br_addr;
        end else begin
          pend_valid <= 1'b1;
          pend_addr  <= br_addr;
        end
      end else if (accept) begin
        if (pend_valid) begin
          pc         <= pend_addr;
          pend_valid <= 1'b0;
        end else begin
          pc <= pc + 32'd4;
        end
      end
    end
  end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction-fetch stage for the five-stage MIPS pipeline. It generates the PC, issues requests to the instruction SRAM over an sram-like req/addr_ok/data_ok handshake, and buffers returned words in a 2-entry FIFO. It delivers instructions to the decode stage on if_to_id_bus/if_inst, and applies branch redirects from decode on br_bus with one architectural delay slot.

## Interface
- RESET_PC, 32'hBFC0_0000, address of the first fetch after reset
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  `StallBus  pipeline stall vector from ctrl
  - stall[0]==`Stop: suppress new requests.
  - stall[1]==`Stop: decode does not accept this cycle.
  - stall[2]==`NoStop: decode hands its instruction to execute this cycle.
- br_bus  in  `BR_WD (33)  {br_e, br_addr}; redirect request from decode
- inst_req  out  1  SRAM request valid
- inst_addr  out  32  SRAM word address (bits [1:0] = 0)
- inst_addr_ok  in  1  request accepted this cycle (inst_req && inst_addr_ok)
- inst_data_ok  in  1  read data valid; responses return in request order
- inst_rdata  in  32  read data
- if_to_id_bus  out  `IF_TO_ID_WD (33)  {valid, pc} of the FIFO head
- if_inst  out  32  instruction word of the FIFO head; 0 when not valid

## Operation
- State:
  - pc: next address to issue.
  - FIFO: 2 entries of {pc, inst}, count q_cnt 0..2.
  - inflight: 0/1 outstanding request, plus pc_inflight and a discard tag.
  - pend_valid / pend_addr: deferred redirect.
  - boot: single idle cycle after reset.
- Pop: at posedge when q_cnt>0 and stall[1]==`NoStop. The head is taken by decode.
- Push: when inst_data_ok, the word is pushed with pc_inflight and inflight clears.
  - If the discard tag is set, the word is dropped and not pushed.
- Issue:
  - inst_req = !boot && stall[0]==`NoStop && (inflight==0 || inst_data_ok) && (q_cnt + inflight - pop) < 2.
  - Occupancy (FIFO + in-flight) therefore never exceeds 2, and data_ok never finds the FIFO full.
  - inst_addr = pc.
  - On acceptance: inflight<=1, pc_inflight<=pc, pc<=pc+4 (modulo 2^32, wraps 0xFFFFFFFC→0), unless a redirect rule below applies.
  - inst_req/inst_addr are combinational. Their values before acceptance may change; the SRAM samples only on addr_ok.
- Redirect is honoured only in cycles with br_e==1 && stall[2]==`NoStop, so a stalled branch redirects exactly once.
- The delay slot is the oldest non-discarded instruction held at cycle start: FIFO head, else in-flight, else the next accepted request. Everything younger is wrong-path.
  - held>=1: pc<=br_addr. FIFO entries behind the head are removed. An in-flight request behind a valid head gets the discard tag. A request accepted this cycle gets the discard tag.
  - held==0 and a request is accepted this cycle: that request is the delay slot; pc<=br_addr.
  - held==0 and no acceptance: pend_valid<=1, pend_addr<=br_addr. The next accepted request (at pc, the delay slot) sets pc<=pend_addr and clears pend_valid.
- A second honoured br_e while pend_valid is set overwrites pend_addr. This cannot occur architecturally.
- Unimplemented encodings and alignment faults are not checked.

## Timing
- Reset values:
  - inst_req=0, inst_addr=RESET_PC.
  - if_to_id_bus=0, if_inst=0.
  - q_cnt=0, inflight=0, pend_valid=0, boot=1, pc=RESET_PC.
- The boot cycle follows rst deassertion. The first inst_req is asserted in the next cycle.
- Latency: accept at cycle A, data_ok at cycle D>A; the entry appears on if_to_id_bus in cycle D+1 when the FIFO is empty.
- Steady state, with addr_ok=1 and data_ok one cycle after accept: one instruction per cycle.
- rst mid-transaction clears all state. The instruction SRAM shares rst, so no stale data_ok follows reset.
- Simultaneous push and pop with q_cnt==1: the count stays 1 and the head advances.
- Simultaneous redirect and data_ok of the delay slot: the word is pushed; the discard applies only to younger requests.

## Test plan
- Reset: hold rst 3 cycles, addr_ok=1 → outputs 0 during rst, boot cycle without request, then inst_req=1 with inst_addr=0xBFC00000.
- Stream: addr_ok=1, data_ok 1 cycle after accept, stall=0 → if_to_id_bus pc 0xBFC00000, 04, 08, 0C on consecutive cycles; if_inst matches SRAM contents.
- Backpressure: stall[1]=`Stop for 4 cycles with the FIFO filling → q_cnt reaches 2, inst_req stays 0, then in-order delivery resumes with no word lost or duplicated.
- Branch with a held delay slot:
  - Setup: a branch in decode, head pc 0xBFC0000C, request 0xBFC00010 in flight, br_bus={1,0xBFC00100}, stall[2]=`NoStop.
  - Required: decode receives 0xBFC0000C then 0xBFC00100; the 0xBFC00010 word is dropped.
- Deferred redirect:
  - Setup: FIFO empty, nothing in flight, addr_ok=0 during the honoured br_e (target 0x00400020).
  - Required: the next accepted addresses are the delay slot (pc) then 0x00400020.
- Wrap and mid-run reset: pc 0xFFFFFFFC → next issue 0x00000000; rst asserted with a request in flight → all outputs return to reset values next cycle and fetch restarts at RESET_PC.
